// File: rtl/if_fetch_unit.sv
// rtl/if_fetch_unit.sv - instruction fetch front end with credit-limited requests and 2-entry response buffer
module if_fetch_unit #(
    parameter int                         INST_WIDTH      = 32,
    parameter int                         INST_ADDR_WIDTH = 32,
    parameter logic [INST_ADDR_WIDTH-1:0] RESET_PC        = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       redirect_i,
    input  logic [INST_ADDR_WIDTH-1:0] redirect_pc_i,
    input  logic                       stall_i,
    output logic                       imem_req_o,
    output logic [INST_ADDR_WIDTH-1:0] imem_addr_o,
    input  logic                       imem_ready_i,
    input  logic                       imem_rvalid_i,
    input  logic [INST_WIDTH-1:0]      imem_rdata_i,
    output logic [INST_WIDTH-1:0]      IF_inst_o,
    output logic [INST_ADDR_WIDTH-1:0] IF_PC_o,
    output logic                       IF_valid_o
);

    localparam logic [0:0] ST_FETCH = 1'b0;
    localparam logic [0:0] ST_FLUSH = 1'b1;

    logic [0:0]                 state;
    logic [INST_ADDR_WIDTH-1:0] fetch_pc;
    logic [1:0]                 outstanding;
    logic [1:0]                 kill_cnt;

    // PCs of accepted requests, in issue order; occupancy equals outstanding
    logic [INST_ADDR_WIDTH-1:0] pcq [0:1];
    logic                       pcq_rd;
    logic                       pcq_wr;

    logic [INST_WIDTH-1:0]      buf_inst [0:1];
    logic [INST_ADDR_WIDTH-1:0] buf_pc   [0:1];
    logic                       buf_rd;
    logic                       buf_wr;
    logic [1:0]                 buf_count;

    logic                       credit;
    logic                       accept;
    logic                       resp;
    logic                       push;
    logic                       pop;
    logic [1:0]                 kill_next;

    logic                       unused_pc_bits;
    assign unused_pc_bits = ^redirect_pc_i[1:0];

    // Credits use registered counts only; same-cycle frees are seen next cycle
    assign credit     = ({1'b0, outstanding} + {1'b0, buf_count}) < 3'd2;
    assign imem_req_o = !rst && (state == ST_FETCH) && !redirect_i && credit;
    assign imem_addr_o = fetch_pc;

    assign accept    = imem_req_o && imem_ready_i;
    assign resp      = imem_rvalid_i && (outstanding != 2'd0);
    assign push      = resp && (state == ST_FETCH) && !redirect_i;
    assign pop       = IF_valid_o && !stall_i;
    assign kill_next = outstanding - {1'b0, resp};

    assign IF_valid_o = (buf_count != 2'd0);
    assign IF_inst_o  = IF_valid_o ? buf_inst[buf_rd] : '0;
    assign IF_PC_o    = IF_valid_o ? buf_pc[buf_rd]   : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_FETCH;
            fetch_pc    <= RESET_PC;
            outstanding <= 2'd0;
            kill_cnt    <= 2'd0;
            pcq_rd      <= 1'b0;
            pcq_wr      <= 1'b0;
            buf_rd      <= 1'b0;
            buf_wr      <= 1'b0;
            buf_count   <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                pcq[i]      <= '0;
                buf_inst[i] <= '0;
                buf_pc[i]   <= '0;
            end
        end else begin
            if (accept) begin
                pcq[pcq_wr] <= fetch_pc;
                pcq_wr      <= ~pcq_wr;
            end
            // Every accepted response retires its PC, whether kept or discarded
            if (resp) begin
                pcq_rd <= ~pcq_rd;
            end
            outstanding <= outstanding + {1'b0, accept} - {1'b0, resp};

            if (redirect_i) begin
                fetch_pc  <= {redirect_pc_i[INST_ADDR_WIDTH-1:2], 2'b00};
                buf_rd    <= 1'b0;
                buf_wr    <= 1'b0;
                buf_count <= 2'd0;
                kill_cnt  <= kill_next;
                state     <= (kill_next != 2'd0) ? ST_FLUSH : ST_FETCH;
            end else begin
                if (accept) begin
                    fetch_pc <= fetch_pc + INST_ADDR_WIDTH'(4);
                end
                if (push) begin
                    buf_inst[buf_wr] <= imem_rdata_i;
                    buf_pc[buf_wr]   <= pcq[pcq_rd];
                    buf_wr           <= ~buf_wr;
                end
                if (pop) begin
                    buf_rd <= ~buf_rd;
                end
                buf_count <= buf_count + {1'b0, push} - {1'b0, pop};
                if ((state == ST_FLUSH) && resp) begin
                    kill_cnt <= kill_cnt - 2'd1;
                    if (kill_cnt == 2'd1) begin
                        state <= ST_FETCH;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// tb/tb_if_fetch_unit.sv - self-checking bench for if_fetch_unit with queue-based reference model
module tb_if_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        stall;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata  = '0;
    logic [31:0] if_inst;
    logic [31:0] if_pc;
    logic        if_valid;

    int total = 0;
    int bad   = 0;

    if_fetch_unit #(.INST_WIDTH(32), .INST_ADDR_WIDTH(32), .RESET_PC(32'h0)) dut (
        .clk           (clk),
        .rst           (rst),
        .redirect_i    (redirect),
        .redirect_pc_i (redirect_pc),
        .stall_i       (stall),
        .imem_req_o    (imem_req),
        .imem_addr_o   (imem_addr),
        .imem_ready_i  (imem_ready),
        .imem_rvalid_i (imem_rvalid),
        .imem_rdata_i  (imem_rdata),
        .IF_inst_o     (if_inst),
        .IF_PC_o       (if_pc),
        .IF_valid_o    (if_valid)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] pc; logic [31:0] inst; } ent_t;
    typedef struct { logic [31:0] addr; int due; } mreq_t;

    ent_t        mbuf[$];
    logic [31:0] minfl[$];
    int          mkill = 0;
    logic [31:0] mpc   = '0;
    mreq_t       mq[$];
    logic [31:0] pops[$];
    int          cyc    = 0;
    int          lat    = 1;
    bit          mem_en = 1'b1;

    function automatic logic [31:0] memf(logic [31:0] a);
        return {a[15:0], ~a[31:16]};
    endfunction

    function automatic void check(string name, logic [31:0] got, logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h (t=%0t)", name, got, exp, $time);
        end
    endfunction

    // Memory responder plus per-cycle compare against the model
    always @(negedge clk) begin
        logic [31:0] p;
        bit          resp, keep, ereq, evalid;
        if (rst) begin
            mq.delete();
            imem_rvalid = 1'b0;
        end else if (mem_en && mq.size() > 0 && cyc >= mq[0].due) begin
            imem_rvalid = 1'b1;
            imem_rdata  = memf(mq[0].addr);
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = 32'hDEAD_BEEF;
        end
        #1;
        if (rst) begin
            check("rst_req", {31'b0, imem_req}, 32'd0);
            check("rst_valid", {31'b0, if_valid}, 32'd0);
            check("rst_inst", if_inst, 32'd0);
            check("rst_pc", if_pc, 32'd0);
            check("rst_addr", imem_addr, 32'h0);
            mbuf.delete();
            minfl.delete();
            mkill = 0;
            mpc   = 32'h0;
        end else begin
            ereq   = (mkill == 0) && !redirect && (minfl.size() + mbuf.size() < 2);
            evalid = mbuf.size() > 0;
            check("req", {31'b0, imem_req}, {31'b0, ereq});
            check("addr", imem_addr, mpc);
            check("valid", {31'b0, if_valid}, {31'b0, evalid});
            if (evalid) begin
                check("if_pc", if_pc, mbuf[0].pc);
                check("if_inst", if_inst, mbuf[0].inst);
            end
            if (if_valid && !stall) pops.push_back(if_pc);

            resp = imem_rvalid && minfl.size() > 0;
            keep = 1'b0;
            p    = '0;
            if (imem_rvalid) void'(mq.pop_front());
            if (resp) begin
                p    = minfl.pop_front();
                keep = (mkill == 0) && !redirect;
                if (mkill > 0) mkill--;
            end
            if (redirect) begin
                mbuf.delete();
                mkill = minfl.size();
                mpc   = redirect_pc & 32'hFFFF_FFFC;
            end else begin
                if (mbuf.size() > 0 && !stall) void'(mbuf.pop_front());
                if (keep) mbuf.push_back('{pc: p, inst: memf(p)});
                if (ereq && imem_ready) begin
                    minfl.push_back(mpc);
                    mq.push_back('{addr: mpc, due: cyc + lat});
                    mpc = mpc + 32'd4;
                end
            end
        end
        cyc++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int m;
        rst = 1'b1; redirect = 1'b0; redirect_pc = '0; stall = 1'b0; imem_ready = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        pops.delete();

        // Sequential fetch, then decode stall while 0x8 is at the head
        for (int i = 0; i < 40 && !(if_valid && if_pc == 32'h8); i++) tick();
        check("s2_reach8", {31'b0, if_valid && if_pc == 32'h8}, 32'd1);
        stall = 1'b1;
        check("s1_popcnt", pops.size(), 32'd2);
        if (pops.size() >= 2) begin
            check("s1_pop0", pops[0], 32'h0);
            check("s1_pop1", pops[1], 32'h4);
        end
        m = pops.size();
        repeat (2) begin
            tick();
            check("s2_hold_pc", if_pc, 32'h8);
            check("s2_hold_valid", {31'b0, if_valid}, 32'd1);
        end
        tick();
        check("s2_no_pop", pops.size(), m);
        stall = 1'b0;
        for (int i = 0; i < 20 && pops.size() < m + 2; i++) tick();
        check("s2_popcnt", {31'b0, pops.size() >= m + 2}, 32'd1);
        if (pops.size() >= m + 2) begin
            check("s2_pop8", pops[m], 32'h8);
            check("s2_popC", pops[m+1], 32'hC);
        end

        // Two in flight at 0x10/0x14, then redirect to 0x100
        lat = 3;
        redirect = 1'b1; redirect_pc = 32'h10;
        tick();
        redirect = 1'b0;
        for (int i = 0; i < 40 && !(minfl.size() == 2 && minfl[0] == 32'h10); i++) tick();
        check("s3_two_inflight", {31'b0, minfl.size() == 2}, 32'd1);
        redirect = 1'b1; redirect_pc = 32'h100;
        m = pops.size();
        tick();
        redirect = 1'b0;
        for (int i = 0; i < 40 && pops.size() <= m; i++) tick();
        check("s3_popcnt", {31'b0, pops.size() > m}, 32'd1);
        if (pops.size() > m) check("s3_pop100", pops[m], 32'h100);

        // Redirect coinciding with the only outstanding response
        lat = 1;
        mem_en = 1'b0;
        for (int i = 0; i < 40 && minfl.size() != 1; i++) tick();
        imem_ready = 1'b0;
        check("s4_one_inflight", minfl.size(), 32'd1);
        tick();
        mem_en = 1'b1;
        redirect = 1'b1; redirect_pc = 32'h100;
        tick();
        redirect = 1'b0;
        imem_ready = 1'b1;
        #1;
        check("s4_req", {31'b0, imem_req}, 32'd1);
        check("s4_addr", imem_addr, 32'h100);

        // Wrap at the top of the address space; low target bits ignored
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFF;
        m = pops.size();
        tick();
        redirect = 1'b0;
        for (int i = 0; i < 40 && pops.size() < m + 2; i++) tick();
        check("s5_popcnt", {31'b0, pops.size() >= m + 2}, 32'd1);
        if (pops.size() >= m + 2) begin
            check("s5_pop_top", pops[m], 32'hFFFF_FFFC);
            check("s5_pop_wrap", pops[m+1], 32'h0);
        end

        // Memory not ready: request and address held
        imem_ready = 1'b0;
        redirect = 1'b1; redirect_pc = 32'h42;
        tick();
        redirect = 1'b0;
        for (int i = 0; i < 20 && !imem_req; i++) tick();
        repeat (4) begin
            check("s6_req_held", {31'b0, imem_req}, 32'd1);
            check("s6_addr_held", imem_addr, 32'h40);
            tick();
        end
        imem_ready = 1'b1;
        repeat (3) tick();

        // Mid-run reset
        rst = 1'b1;
        #1;
        check("s6_rst_req", {31'b0, imem_req}, 32'd0);
        check("s6_rst_valid", {31'b0, if_valid}, 32'd0);
        check("s6_rst_pc", if_pc, 32'd0);
        check("s6_rst_addr", imem_addr, 32'h0);
        repeat (2) tick();
        rst = 1'b0;
        m = pops.size();
        for (int i = 0; i < 40 && pops.size() <= m; i++) tick();
        check("s6_refetch_cnt", {31'b0, pops.size() > m}, 32'd1);
        if (pops.size() > m) check("s6_refetch_pc", pops[m], 32'h0);
        repeat (3) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
